// File: rtl/tw_ctrl_pkg.sv
// Shared types and ROM-facing codes for the twiddle-ROM sequencing controller.
package tw_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_HI,
      LOAD_LO,
      RUN,
      DONE
   } ctrl_state_e;

   localparam logic [3:0] ST_CODE_IDLE  = 4'd0;
   localparam logic [3:0] ST_CODE_LOAD  = 4'd2;
   localparam logic [3:0] ST_CODE_STAGE = 4'd4;
   localparam logic [3:0] ST_CODE_FINAL = 4'd6;

   localparam logic [1:0] ROM7_NONE  = 2'd0;
   localparam logic [1:0] ROM7_UPPER = 2'd1;
   localparam logic [1:0] ROM7_LOWER = 2'd2;

   localparam logic [2:0] STAGE_IDLE = 3'd7;

endpackage

// File: rtl/tw_load_serializer.sv
// Four-slot twiddle buffer: captures load words, then replays upper halves
// followed by lower halves in slot order.
module tw_load_serializer
   import tw_ctrl_pkg::*;
#(
   parameter int P_WIDTH = 128
) (
   input  logic                 CLK,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic [P_WIDTH-1:0]   wr_data,
   input  logic                 rd_hi,
   input  logic                 rd_lo,
   output logic [1:0]           wr_idx,
   output logic                 wr_last,
   output logic                 rd_last,
   output logic [1:0]           rom7_w,
   output logic [P_WIDTH/2-1:0] half_out
);

   localparam int HW = P_WIDTH / 2;

   logic [P_WIDTH-1:0] slot [4];
   logic [1:0]         rd_idx;

   always_ff @(posedge CLK) begin
      if (rst) begin
         wr_idx <= '0;
         rd_idx <= '0;
      end else begin
         if (wr_en) wr_idx <= wr_idx + 2'd1;
         // one index walks both halves; it wraps to 0 between LOAD_HI and LOAD_LO
         if (rd_hi || rd_lo) rd_idx <= rd_idx + 2'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (wr_en) slot[wr_idx] <= wr_data;
   end

   assign wr_last = wr_en && (wr_idx == 2'd3);
   assign rd_last = (rd_idx == 2'd3);

   always_comb begin
      rom7_w   = ROM7_NONE;
      half_out = '0;
      if (rd_hi) begin
         rom7_w   = ROM7_UPPER;
         half_out = slot[rd_idx][P_WIDTH-1:HW];
      end else if (rd_lo) begin
         rom7_w   = ROM7_LOWER;
         half_out = slot[rd_idx][HW-1:0];
      end
   end

endmodule

// File: rtl/tw_rom_seq_ctrl.sv
// Twiddle-ROM sequencer: loads ROM7 via half-word writes, then steps NTT stages.
// Define TW_CTRL_STALL_EN to let 'hold' stall the RUN phase.
module tw_rom_seq_ctrl
   import tw_ctrl_pkg::*;
#(
   parameter int STAGE_NUM = 3,
   parameter int STAGE_LEN = 1024,
   parameter int P_WIDTH   = 128
) (
   input  logic                 CLK,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 hold,
   input  logic                 load_valid,
   input  logic [P_WIDTH-1:0]   load_data,
   output logic                 load_ready,
   output logic [2:0]           stage_counter,
   output logic                 CEN,
   output logic [3:0]           state,
   output logic [1:0]           ROM7_w,
   output logic [P_WIDTH/2-1:0] horizontal_data_out,
   output logic                 busy,
   output logic                 done
);

   localparam int             CW       = $clog2(STAGE_LEN);
   localparam logic [CW-1:0]  CNT_LAST = CW'(STAGE_LEN - 1);
   localparam logic [2:0]     STG_LAST = 3'(STAGE_NUM - 1);

   ctrl_state_e   cur_st, nxt_st;
   logic [CW-1:0] cyc_cnt;
   logic [2:0]    stg_cnt;
   logic [1:0]    wr_idx;
   logic          wr_last, rd_last;
   logic          run_go, load_hs, held, stage_end;

`ifdef TW_CTRL_STALL_EN
   assign held = (cur_st == RUN) && hold;
`else
   logic unused_hold;
   assign unused_hold = hold;
   assign held        = 1'b0;
`endif

   assign run_go     = (cur_st == IDLE) && start && (wr_idx == 2'd0);
   assign load_ready = (cur_st == IDLE) && !run_go;
   assign load_hs    = load_valid && load_ready;
   assign stage_end  = (cur_st == RUN) && !held && (cyc_cnt == CNT_LAST);

   tw_load_serializer #(.P_WIDTH(P_WIDTH)) u_ser (
      .CLK      (CLK),
      .rst      (rst),
      .wr_en    (load_hs),
      .wr_data  (load_data),
      .rd_hi    (cur_st == LOAD_HI),
      .rd_lo    (cur_st == LOAD_LO),
      .wr_idx   (wr_idx),
      .wr_last  (wr_last),
      .rd_last  (rd_last),
      .rom7_w   (ROM7_w),
      .half_out (horizontal_data_out)
   );

   always_ff @(posedge CLK) begin
      if (rst) begin
         cur_st  <= IDLE;
         cyc_cnt <= '0;
         stg_cnt <= '0;
      end else begin
         cur_st <= nxt_st;
         if (cur_st == RUN && !held) begin
            if (stage_end) begin
               cyc_cnt <= '0;
               stg_cnt <= (stg_cnt == STG_LAST) ? 3'd0 : stg_cnt + 3'd1;
            end else begin
               cyc_cnt <= cyc_cnt + 1'b1;
            end
         end
      end
   end

   always_comb begin
      nxt_st        = cur_st;
      CEN           = 1'b1;
      stage_counter = STAGE_IDLE;
      state         = ST_CODE_IDLE;
      busy          = 1'b1;
      done          = 1'b0;
      case (cur_st)
         IDLE: begin
            busy = 1'b0;
            if (run_go)       nxt_st = RUN;
            else if (wr_last) nxt_st = LOAD_HI;
         end
         LOAD_HI: begin
            state = ST_CODE_LOAD;
            if (rd_last) nxt_st = LOAD_LO;
         end
         LOAD_LO: begin
            state = ST_CODE_LOAD;
            if (rd_last) nxt_st = IDLE;
         end
         RUN: begin
            state = (stg_cnt == STG_LAST) ? ST_CODE_FINAL : ST_CODE_STAGE;
            if (!held) begin
               CEN           = 1'b0;
               stage_counter = stg_cnt;
               if (stage_end && stg_cnt == STG_LAST) nxt_st = DONE;
            end
         end
         DONE: begin
            done   = 1'b1;
            nxt_st = IDLE;
         end
         default: nxt_st = IDLE;
      endcase
   end

endmodule

// File: tb/tb_tw_rom_seq_ctrl.sv
// Self-checking bench for tw_rom_seq_ctrl (STAGE_NUM=3, STAGE_LEN=16); expectations
// follow TW_CTRL_STALL_EN when it is defined for the build.
module tb_tw_rom_seq_ctrl;

   localparam int SN = 3;
   localparam int SL = 16;
   localparam int PW = 128;
   localparam int HW = PW / 2;
`ifdef TW_CTRL_STALL_EN
   localparam bit STALL = 1'b1;
`else
   localparam bit STALL = 1'b0;
`endif

   logic          CLK = 1'b0;
   logic          rst, start, hold, load_valid;
   logic [PW-1:0] load_data;
   logic          load_ready, CEN, busy, done;
   logic [2:0]    stage_counter;
   logic [3:0]    state;
   logic [1:0]    ROM7_w;
   logic [HW-1:0] horizontal_data_out;

   logic [PW-1:0] words [4];
   int n_tests = 0;
   int n_fail  = 0;

   always #5 CLK = ~CLK;

   tw_rom_seq_ctrl #(.STAGE_NUM(SN), .STAGE_LEN(SL), .P_WIDTH(PW)) dut (
      .CLK                 (CLK),
      .rst                 (rst),
      .start               (start),
      .hold                (hold),
      .load_valid          (load_valid),
      .load_data           (load_data),
      .load_ready          (load_ready),
      .stage_counter       (stage_counter),
      .CEN                 (CEN),
      .state               (state),
      .ROM7_w              (ROM7_w),
      .horizontal_data_out (horizontal_data_out),
      .busy                (busy),
      .done                (done)
   );

   task automatic chk(input string tag, input logic [HW-1:0] obs, input logic [HW-1:0] want);
      n_tests++;
      assert (obs === want) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_ready"}, load_ready, 1);
      chk({tag, "_cen"}, CEN, 1);
      chk({tag, "_stage"}, stage_counter, 7);
      chk({tag, "_state"}, state, 0);
      chk({tag, "_rom7w"}, ROM7_w, 0);
      chk({tag, "_hdo"}, horizontal_data_out, 0);
      chk({tag, "_done"}, done, 0);
   endtask

   task automatic rand_words();
      for (int i = 0; i < 4; i++) words[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
   endtask

   task automatic do_load(input int first, input int cnt);
      for (int i = first; i < first + cnt; i++) begin
         load_valid = 1'b1;
         load_data  = words[i];
         #1;
         chk("load_ready_hs", load_ready, 1);
         tick();
      end
      load_valid = 1'b0;
      load_data  = '0;
   endtask

   // eight ROM writes: all upper halves in slot order, then all lower halves
   task automatic check_load_seq();
      for (int j = 0; j < 8; j++) begin
         #1;
         chk("seq_rom7w", ROM7_w, (j < 4) ? 1 : 2);
         chk("seq_hdo", horizontal_data_out, (j < 4) ? words[j][PW-1:HW] : words[j-4][HW-1:0]);
         chk("seq_state", state, 2);
         chk("seq_ready", load_ready, 0);
         chk("seq_cen", CEN, 1);
         tick();
      end
      #1;
      check_idle("seq_end");
      tick();
   endtask

   // k = non-held RUN cycles consumed so far; stage and state follow from k alone
   task automatic do_run(input int hold_t, input int hold_len, input bit with_load, input int abort_t);
      int k = 0;
      int t = 0;
      int cen_low = 0;
      int stg;
      bit h, hd;
      start      = 1'b1;
      load_valid = with_load;
      load_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      #1;
      chk("start_ready_low", load_ready, 0);
      tick();
      start      = 1'b0;
      load_valid = 1'b0;
      while (k < SN * SL) begin
         h    = (t >= hold_t) && (t < hold_t + hold_len);
         hold = h;
         rst  = (t == abort_t);
         #1;
         stg = k / SL;
         hd  = STALL && h;
         chk("run_cen", CEN, hd ? 1 : 0);
         chk("run_stage", stage_counter, hd ? 7 : stg);
         chk("run_state", state, (stg == SN - 1) ? 6 : 4);
         chk("run_busy", busy, 1);
         chk("run_done", done, 0);
         if (CEN === 1'b0) cen_low++;
         if (t == abort_t) begin
            tick();
            rst  = 1'b0;
            hold = 1'b0;
            #1;
            check_idle("abort");
            for (int i = 0; i < 3; i++) begin
               tick();
               #1;
               chk("abort_no_done", done, 0);
               chk("abort_busy", busy, 0);
            end
            tick();
            return;
         end
         if (!hd) k++;
         t++;
         tick();
      end
      hold = 1'b0;
      #1;
      chk("done_pulse", done, 1);
      chk("done_state", state, 0);
      chk("done_cen", CEN, 1);
      chk("done_busy", busy, 1);
      chk("cen_low_total", cen_low, SN * SL);
      tick();
      #1;
      chk("post_done", done, 0);
      check_idle("post_run");
      tick();
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      hold       = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;
      repeat (3) tick();
      rst = 1'b0;
      #1;
      check_idle("reset");
      tick();

      words[0] = {{16{4'hA}}, {16{4'hB}}};
      words[1] = {32{4'hC}};
      words[2] = {32{4'hD}};
      words[3] = {32{4'hE}};
      do_load(0, 4);
      check_load_seq();

      repeat (2) begin
         rand_words();
         do_load(0, 4);
         check_load_seq();
      end

      do_run(-1, 0, 1'b0, -1);
      do_run(SL + 7, 5, 1'b0, -1);
      repeat (3) do_run(int'($urandom_range(0, 45)), int'($urandom_range(1, 6)), 1'b0, -1);

      // start with a simultaneous load offer: a captured word would shift the load sequence
      do_run(-1, 0, 1'b1, -1);
      rand_words();
      do_load(0, 4);
      check_load_seq();

      rand_words();
      do_load(0, 2);
      start = 1'b1;
      #1;
      chk("partial_start_ready", load_ready, 1);
      tick();
      start = 1'b0;
      #1;
      chk("partial_start_busy", busy, 0);
      chk("partial_start_state", state, 0);
      tick();
      do_load(2, 2);
      check_load_seq();

      do_run(-1, 0, 1'b0, SL + 3);
      do_run(-1, 0, 1'b0, -1);

      rand_words();
      do_load(0, 4);
      #1;
      chk("abort_load_first", ROM7_w, 1);
      tick();
      rst = 1'b1;
      #1;
      chk("abort_load_pre", ROM7_w, 1);
      tick();
      rst = 1'b0;
      #1;
      check_idle("abort_load");
      tick();
      do_run(-1, 0, 1'b0, -1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/tw_rom_seq_ctrl.md
TW_ROM_SEQ_CTRL -- requirements
Module: tw_rom_seq_ctrl

Interface
REQ-001 Parameter: STAGE_NUM, 3, number of NTT stages sequenced per run (1..7).
REQ-002 Parameter: STAGE_LEN, 1024, cycles of CEN-low per stage (power of two, 4..65536).
REQ-003 Parameter: P_WIDTH, 128, twiddle word width; horizontal half-width is P_WIDTH/2.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 Port: CLK  in  1  sole clock; all state updates on rising edge.
REQ-006 Port: rst  in  1  synchronous active-high reset.
REQ-007 Port: start  in  1  run request; sampled in IDLE only.
REQ-008 Port: hold  in  1  stall request during RUN.
REQ-009 Port: load_valid  in  1  load word offered.
REQ-010 Port: load_data  in  P_WIDTH  twiddle word for stage-0 slot.
REQ-011 Port: load_ready  out  1  high in IDLE when no RUN is pending.
REQ-012 Port: stage_counter  out  3  stage index to ROM.
REQ-013 Port: CEN  out  1  active-low ROM enable.
REQ-014 Port: state  out  4  phase code to ROM.
REQ-015 Port: ROM7_w  out  2  ROM write select: 1 upper half, 2 lower half, 0 none.
REQ-016 Port: horizontal_data_out  out  P_WIDTH/2  half-word to ROM.
REQ-017 Port: busy  out  1  high in any state except IDLE.
REQ-018 Port: done  out  1  one-cycle pulse at end of run.

Function
REQ-019 FSM states SHALL be IDLE, LOAD_HI, LOAD_LO, RUN, DONE.
REQ-020 IDLE: load handshake when load_valid&&load_ready; word stored in slot wr_idx (0..3); wr_idx increments; the 4th handshake moves the FSM to LOAD_HI next cycle with wr_idx wrapping to 0.
REQ-021 LOAD_HI: 4 cycles, ROM7_w=1, horizontal_data_out=slot[i][P_WIDTH-1:P_WIDTH/2], i=0..3 in order; then LOAD_LO.
REQ-022 LOAD_LO: 4 cycles, ROM7_w=2, lower halves slot[0..3]; then IDLE; load_ready low throughout LOAD_HI/LOAD_LO.
REQ-023 start in IDLE with wr_idx==0 SHALL enter RUN the next cycle; start with wr_idx!=0 (partial load) SHALL be ignored.
REQ-024 start and load_valid in the same IDLE cycle: start wins; no load handshake (load_ready low that cycle).
REQ-025 RUN: stage_counter counts 0..STAGE_NUM-1; each stage holds CEN=0 for exactly STAGE_LEN non-held cycles; stage_counter increments on the cycle after the last one.
REQ-026 state=4 for stages 0..STAGE_NUM-2, 6 for the final stage; state=0 in IDLE/DONE, 2 in LOAD_HI/LOAD_LO.
REQ-027 hold in RUN: CEN=1, cycle counter and stage_counter frozen, state unchanged; resume on the cycle after hold falls.
REQ-028 After the last cycle of the final stage: DONE for one cycle (done=1), then IDLE.
REQ-029 Outside RUN (or held): CEN=1 and stage_counter=7.
REQ-030 ROM7_w=0 and horizontal_data_out=0 outside LOAD_HI/LOAD_LO.
REQ-031 Cycle counter width SHALL be clog2(STAGE_LEN); wrap at STAGE_LEN-1 only, with no carry into other fields.

Reset
REQ-032 rst SHALL force IDLE, wr_idx=0, all counters 0, CEN=1, stage_counter=7, state=0, ROM7_w=0, horizontal_data_out=0, busy=0, done=0, load_ready=1 (from the next cycle); slot contents are don't-care.
REQ-033 rst asserted mid-LOAD or mid-RUN SHALL abort immediately with no further ROM writes and no done pulse.

Configuration
REQ-034 Macro TW_CTRL_STALL_EN: when defined, hold behaves per REQ-027; when undefined, hold is ignored and RUN always completes in exactly STAGE_NUM*STAGE_LEN cycles.

Structure
REQ-035 Package tw_ctrl_pkg SHALL hold the FSM state enum, state-code constants (0, 2, 4, 6), ROM7_w codes, and the idle stage_counter value 7.
REQ-036 Sub-module tw_load_serializer SHALL hold the 4-slot buffer and drive the LOAD_HI/LOAD_LO half-word sequence.

Verification
REQ-037 Load words 0xA..A_B..B, C, D, E (4 handshakes) -> ROM7_w=1 for 4 cycles with upper halves in slot order, then ROM7_w=2 for 4 cycles with lower halves, then load_ready=1.
REQ-038 STAGE_NUM=3, STAGE_LEN=16, start pulse -> CEN low for 48 cycles; stage_counter 0,1,2 for 16 cycles each; state 4,4,6; done high one cycle after.
REQ-039 TW_CTRL_STALL_EN defined, hold for 5 cycles at stage-1 cycle 7 -> CEN=1 for 5 cycles, total RUN=53 cycles; undefined -> 48 cycles.
REQ-040 2 load handshakes then start -> start ignored, busy stays 0; 2 more loads -> LOAD sequence runs.
REQ-041 rst at RUN stage 1 cycle 3 -> next cycle IDLE, CEN=1, stage_counter=7, no done pulse.
REQ-042 start and load_valid together in IDLE -> RUN entered, load word not captured (wr_idx stays 0).
